// File: rtl/dual_port_ram_pkg.sv
// Shared constants for the true dual-port RAM: default data/address MSB
// indices and the highest valid word index.
package dual_port_ram_pkg;

    localparam int DPR_DATA_WIDTH = 7;   // data MSB index -> 8-bit words
    localparam int DPR_ADDR_WIDTH = 5;   // address MSB index -> 6-bit addresses
    localparam int DPR_RAM_LOC    = 63;  // highest valid location -> 64 words

endpackage : dual_port_ram_pkg

// File: rtl/dual_port_ram.sv
// True dual-port RAM: two independent registered read/write ports on one
// flop-based array. Port A wins same-address write collisions.
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DPR_DATA_WIDTH,
    parameter int ADDR_WIDTH = DPR_ADDR_WIDTH,
    parameter int RAM_LOC    = DPR_RAM_LOC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH:0]   data_A,
    input  logic [DATA_WIDTH:0]   data_B,
    input  logic [ADDR_WIDTH:0]   addr_A,
    input  logic [ADDR_WIDTH:0]   addr_B,
    input  logic                  w_A,
    input  logic                  w_B,
    output logic [DATA_WIDTH:0]   q_A,
    output logic [DATA_WIDTH:0]   q_B
);

    logic [DATA_WIDTH:0] mem_q [0:RAM_LOC];
    logic [DATA_WIDTH:0] mem_d [0:RAM_LOC];
    logic [DATA_WIDTH:0] q_a_q, q_a_d;
    logic [DATA_WIDTH:0] q_b_q, q_b_d;
    logic                a_valid, b_valid;

    assign a_valid = (32'(addr_A) <= RAM_LOC);
    assign b_valid = (32'(addr_B) <= RAM_LOC);

    // Port A is applied last so it overrides port B on a same-address write.
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no path leaves it unassigned and no latch is inferred.
        mem_d = mem_q;
        if (w_B && b_valid) begin
            mem_d[addr_B] = data_B;
        end
        if (w_A && a_valid) begin
            mem_d[addr_A] = data_A;
        end
    end

    // Reads see mem_q (pre-edge contents), giving read-before-write across ports.
    always_comb begin
        q_a_d = '0;
        q_b_d = '0;
        if (w_A) begin
            q_a_d = data_A;
        end else if (a_valid) begin
            q_a_d = mem_q[addr_A];
        end
        if (w_B) begin
            q_b_d = data_B;
        end else if (b_valid) begin
            q_b_d = mem_q[addr_B];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a_q <= '0;
            q_b_q <= '0;
            // NOTE: the array is built from resettable flops because every word must read 0 while rst is high; a macro RAM could not do that.
            for (int i = 0; i <= RAM_LOC; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
            mem_q <= mem_d;
        end
    end

    assign q_A = q_a_q;
    assign q_B = q_b_q;

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: a reference memory model pushes the
// expected q_A/q_B per cycle into scoreboard queues, popped after each edge.
module tb_dual_port_ram;

    logic       clk;
    logic       rst;
    logic [7:0] data_A, data_B;
    logic [5:0] addr_A, addr_B;
    logic       w_A, w_B;
    logic [7:0] q_A, q_B;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl [0:63];
    logic [7:0] exp_a_q [$];
    logic [7:0] exp_b_q [$];

    dual_port_ram dut (
        .clk    (clk),
        .rst    (rst),
        .data_A (data_A),
        .data_B (data_B),
        .addr_A (addr_A),
        .addr_B (addr_B),
        .w_A    (w_A),
        .w_B    (w_B),
        .q_A    (q_A),
        .q_B    (q_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
        exp_a_q.delete();
        exp_b_q.delete();
    endtask

    // One clock cycle of traffic; called at posedge+1, returns at next posedge+1.
    task automatic drive(input logic wa, input logic [5:0] aa, input logic [7:0] da,
                         input logic wb, input logic [5:0] ab, input logic [7:0] db,
                         input string tag);
        logic [7:0] ea, eb;
        w_A = wa; addr_A = aa; data_A = da;
        w_B = wb; addr_B = ab; data_B = db;
        ea = wa ? da : mdl[aa];
        eb = wb ? db : mdl[ab];
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        if (wb) mdl[ab] = db;
        if (wa) mdl[aa] = da;
        @(posedge clk);
        #1;
        check({tag, "_qA"}, q_A, exp_a_q.pop_front());
        check({tag, "_qB"}, q_B, exp_b_q.pop_front());
    endtask

    task automatic idle_inputs();
        w_A = 1'b0; w_B = 1'b0;
        addr_A = '0; addr_B = '0;
        data_A = '0; data_B = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_clear();
        #2;
        check("rst_async_qA", q_A, 8'h00);
        check("rst_async_qB", q_B, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_hold_qA", q_A, 8'h00);

        // Port A writes addr 0,3,...,30 with addr+2; port B reads them back.
        for (int a = 0; a <= 30; a += 3)
            drive(1'b1, 6'(a), 8'(a + 2), 1'b0, 6'd0, 8'h00, "wrA");
        for (int a = 0; a <= 30; a += 3) begin
            drive(1'b0, 6'd0, 8'h00, 1'b0, 6'(a), 8'h00, "rdB");
            if (a == 3) check("rdB_addr3", q_B, 8'b0000_0101);
        end
        drive(1'b0, 6'd0, 8'h00, 1'b0, 6'd1, 8'h00, "rdB_unwr");
        check("rdB_addr1", q_B, 8'h00);

        // Concurrent: A writes even addresses with addr+3 while B sweeps.
        for (int k = 0; k <= 30; k++) begin
            drive(k % 2 == 0, 6'(k), 8'(k + 3), 1'b0, 6'(k), 8'h00, "conc");
            if (k == 6) check("conc_addr6_old", q_B, 8'd8);
        end
        drive(1'b0, 6'd0, 8'h00, 1'b0, 6'd6, 8'h00, "conc_rd6");
        check("conc_addr6_new", q_B, 8'd9);

        // Write collision on addr 10.
        drive(1'b1, 6'd10, 8'hAA, 1'b1, 6'd10, 8'h55, "coll");
        check("coll_qA", q_A, 8'hAA);
        check("coll_qB", q_B, 8'h55);
        drive(1'b0, 6'd10, 8'h00, 1'b0, 6'd10, 8'h00, "coll_rd");
        check("coll_rdA", q_A, 8'hAA);
        check("coll_rdB", q_B, 8'hAA);

        // Write-through at the top location.
        drive(1'b1, 6'd63, 8'hFF, 1'b0, 6'd0, 8'h00, "wt63");
        check("wt63_qA", q_A, 8'hFF);
        drive(1'b0, 6'd0, 8'h00, 1'b0, 6'd63, 8'h00, "wt63_rd");
        check("wt63_rdB", q_B, 8'hFF);

        // Random mixed traffic against the model.
        for (int n = 0; n < 60; n++)
            drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom),
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom), "rand");

        // Mid-run reset: asserted between edges, writes attempted while held.
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_qA", q_A, 8'h00);
        check("mid_rst_qB", q_B, 8'h00);
        w_A = 1'b1; addr_A = 6'd5;  data_A = 8'h77;
        w_B = 1'b1; addr_B = 6'd62; data_B = 8'h66;
        @(posedge clk);
        #1;
        check("rst_blk_qA", q_A, 8'h00);
        check("rst_blk_qB", q_B, 8'h00);
        rst = 1'b0;
        model_clear();
        drive(1'b0, 6'd5, 8'h00, 1'b0, 6'd62, 8'h00, "post_rst");
        check("post_rst_addr5", q_A, 8'h00);
        check("post_rst_addr62", q_B, 8'h00);
        drive(1'b0, 6'd6, 8'h00, 1'b0, 6'd63, 8'h00, "post_rst2");
        check("post_rst_addr6", q_A, 8'h00);
        check("post_rst_addr63", q_B, 8'h00);

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dual_port_ram
